// File: rtl/sha3_sched_pkg.sv
// Shared constants and types for the SHA3-512 datapath scheduler.
package sha3_sched_pkg;

  localparam int unsigned RATE    = 576;
  localparam int unsigned DIGEST  = 512;
  localparam int unsigned STATE_W = 1600;
  localparam int unsigned MSG_W   = 512;
  localparam int unsigned DIG_HI  = STATE_W - 1;
  localparam int unsigned DIG_LO  = STATE_W - DIGEST;

  typedef enum logic [1:0] {
    StIdle,
    StPad,
    StPerm,
    StHold
  } sched_state_e;

  typedef enum logic [1:0] {
    LEN_0B  = 2'd0,
    LEN_32B = 2'd1,
    LEN_64B = 2'd2,
    LEN_BAD = 2'd3
  } len_code_e;

endpackage

// File: rtl/sha3_512_sched_if.sv
// Requester-side bundle: request/message in, grant and digest handshake out.
interface sha3_512_sched_if;
  import sha3_sched_pkg::*;

  logic [1:0]        req;
  logic [MSG_W-1:0]  msg0;
  logic [MSG_W-1:0]  msg1;
  logic [1:0]        bnum0;
  logic [1:0]        bnum1;
  logic [1:0]        gnt;
  logic              busy;
  logic [DIGEST-1:0] digest;
  logic [1:0]        digest_valid;
  logic [1:0]        digest_ack;
  logic              err;

  modport master (
    output req, msg0, msg1, bnum0, bnum1, digest_ack,
    input  gnt, busy, digest, digest_valid, err
  );

  modport slave (
    input  req, msg0, msg1, bnum0, bnum1, digest_ack,
    output gnt, busy, digest, digest_valid, err
  );

endinterface

// File: rtl/sha3_rr_arb.sv
// Two-way round-robin pick; ptr = 0 favours requester 0 on a tie.
module sha3_rr_arb (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       update,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    if (update) begin
      case (req)
        2'b01:   win = 2'b01;
        2'b10:   win = 2'b10;
        2'b11:   win = ptr ? 2'b10 : 2'b01;
        default: win = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/sha3_512_sched.sv
// Shares one SHA3-512 padder + Keccak-f core between two requesters.
// Optional permutation watchdog: define SHA3_SCHED_TIMEOUT_EN.
module sha3_512_sched #(
  parameter int unsigned RATE    = sha3_sched_pkg::RATE,
  parameter int unsigned DIGEST  = sha3_sched_pkg::DIGEST,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  sha3_512_sched_if.slave                     bus,
  output logic [sha3_sched_pkg::MSG_W-1:0]    pad_in,
  output logic [1:0]                          pad_byte_num,
  input  logic [RATE-1:0]                     pad_out,
  input  logic                                pad_out_ready,
  output logic                                perm_start,
  output logic [sha3_sched_pkg::STATE_W-1:0]  perm_in,
  input  logic                                perm_done,
  input  logic [sha3_sched_pkg::STATE_W-1:0]  perm_out
);
  import sha3_sched_pkg::*;

  sched_state_e       state_q;
  logic [MSG_W-1:0]   msg_q;
  logic [1:0]         bnum_q;
  logic               owner_q;
  logic               ptr_q;
  logic [1:0]         gnt_q;
  logic [1:0]         valid_q;
  logic               err_q;
  logic               perm_start_q;
  logic [DIGEST-1:0]  digest_q;
  logic [STATE_W-1:0] perm_in_q;

  logic [1:0]       win;
  logic             win_idx;
  logic [MSG_W-1:0] win_msg;
  logic [1:0]       win_bnum;
  logic [1:0]       owner_oh;
  logic             tmo_hit;

  sha3_rr_arb u_arb (
    .req    (bus.req),
    .ptr    (ptr_q),
    .update (state_q == StIdle),
    .win    (win)
  );

  assign win_idx  = win[1];
  assign win_msg  = win_idx ? bus.msg1  : bus.msg0;
  assign win_bnum = win_idx ? bus.bnum1 : bus.bnum0;
  assign owner_oh = owner_q ? 2'b10 : 2'b01;

`ifdef SHA3_SCHED_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  logic [TmoW-1:0] tmo_q;

  // Counts edges spent in PERM; cleared whenever we are elsewhere.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else if (state_q == StPerm) begin
      tmo_q <= tmo_q + 1'b1;
    end else begin
      tmo_q <= '0;
    end
  end

  assign tmo_hit = (tmo_q == TmoW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      msg_q        <= '0;
      bnum_q       <= '0;
      owner_q      <= 1'b0;
      ptr_q        <= 1'b0;
      gnt_q        <= '0;
      valid_q      <= '0;
      err_q        <= 1'b0;
      perm_start_q <= 1'b0;
      digest_q     <= '0;
      perm_in_q    <= '0;
    end else begin
      gnt_q        <= '0;
      perm_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|win) begin
            msg_q   <= win_msg;
            bnum_q  <= win_bnum;
            owner_q <= win_idx;
            gnt_q   <= win;
            // Illegal length skips the datapath and reports straight away.
            if (win_bnum == LEN_BAD) begin
              err_q    <= 1'b1;
              digest_q <= '0;
              valid_q  <= win;
              state_q  <= StHold;
            end else begin
              state_q <= StPad;
            end
          end
        end
        StPad: begin
          if (pad_out_ready) begin
            perm_in_q    <= {pad_out, {(STATE_W - RATE){1'b0}}};
            perm_start_q <= 1'b1;
            state_q      <= StPerm;
          end
        end
        StPerm: begin
          if (perm_done) begin
            digest_q <= perm_out[STATE_W-1 -: DIGEST];
            valid_q  <= owner_oh;
            state_q  <= StHold;
          end else if (tmo_hit) begin
            digest_q <= '0;
            err_q    <= 1'b1;
            valid_q  <= owner_oh;
            state_q  <= StHold;
          end
        end
        StHold: begin
          if (bus.digest_ack[owner_q]) begin
            valid_q <= '0;
            err_q   <= 1'b0;
            ptr_q   <= ~owner_q;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Capacity bits of the permuted state never reach the digest.
  logic unused_perm_out;
  assign unused_perm_out = ^perm_out[DIG_LO-1:0];

  assign bus.gnt          = gnt_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.digest       = digest_q;
  assign bus.digest_valid = valid_q;
  assign bus.err          = err_q;
  assign pad_in           = msg_q;
  assign pad_byte_num     = bnum_q;
  assign perm_start       = perm_start_q;
  assign perm_in          = perm_in_q;

endmodule
